// File: rtl/rr_arb_mux_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and limits for the round-robin arbitrating multiplexer.
//   arb_mode_e  : arbitration policy selector (round-robin / fixed priority)
//   ARB_N_MIN/MAX : legal range for the channel-count parameter N
//   src_width() : source-index width, never narrower than one bit
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int ARB_N_MIN = 2;
    localparam int ARB_N_MAX = 32;

    // Index width for n channels; a single channel would still need one bit.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// -----------------------------------------------------------------------------
// rr_arb_mux_if
// Bundles the N-channel input side and the single registered output side.
//   prio_mode        : 0 = round-robin, 1 = fixed priority (lowest index)
//   in_valid/in_data : per-channel requests and data words
//   in_ready         : per-channel accept, one-hot or zero
//   out_valid/out_data/out_src : registered selected word and its channel
//   out_ready        : downstream accept
// modport slave  : the arbiter (rr_arb_mux)
// modport master : whoever drives the channels and sinks the output
// -----------------------------------------------------------------------------
interface rr_arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 16
);
    localparam int SRC_W = arb_pkg::src_width(N);

    logic                 prio_mode;
    logic [N-1:0]         in_valid;
    logic [WIDTH-1:0]     in_data [N];
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SRC_W-1:0]     out_src;
    logic                 out_ready;

    modport slave (
        input  prio_mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

    modport master (
        output prio_mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational grant selection.
//   req   : per-channel requests
//   ptr   : round-robin start index (ignored in fixed mode)
//   mode  : ARB_RR scans ptr..N-1,0..ptr-1; ARB_FIXED scans 0..N-1
//   grant : one-hot grant (zero when no request)
//   idx   : encoded index of the granted channel (zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]                req,
    input  logic [src_width(N)-1:0]     ptr,
    input  arb_mode_e                   mode,
    output logic [N-1:0]                grant,
    output logic [src_width(N)-1:0]     idx
);
    localparam int SRC_W = src_width(N);

    logic [SRC_W:0]   sum_s;
    logic [SRC_W-1:0] pos_s;
    logic             found_s;

    // Walk the channels in scan order and take the first request seen.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        pos_s   = '0;
        for (int k = 0; k < N; k++) begin
            // One extra bit on the sum so ptr+k cannot overflow before the wrap.
            if (mode == ARB_FIXED) begin
                sum_s = (SRC_W+1)'(k);
            end else begin
                sum_s = {1'b0, ptr} + (SRC_W+1)'(k);
            end
            if (sum_s >= (SRC_W+1)'(N)) begin
                sum_s = sum_s - (SRC_W+1)'(N);
            end else begin
                sum_s = sum_s;
            end
            pos_s = sum_s[SRC_W-1:0];
            if (!found_s && req[pos_s]) begin
                found_s      = 1'b1;
                grant[pos_s] = 1'b1;
                idx          = pos_s;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
// N-input arbitrating multiplexer with a single registered output stage.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_arb_mux_if.slave (channel inputs, in_ready, registered output)
// A channel is accepted whenever the output register is empty or being
// drained this cycle, so back-to-back transfers run at one word per cycle.
// -----------------------------------------------------------------------------
module rr_arb_mux
    import arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arb_mux_if.slave    bus
);
    localparam int SRC_W = src_width(N);

    generate
        if (N < ARB_N_MIN || N > ARB_N_MAX) begin : g_bad_n
            $error("rr_arb_mux: N=%0d outside %0d..%0d", N, ARB_N_MIN, ARB_N_MAX);
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("rr_arb_mux: WIDTH=%0d must be at least 1", WIDTH);
        end
    endgenerate

    arb_mode_e           mode_s;
    logic [N-1:0]        grant_s;
    logic [SRC_W-1:0]    idx_s;
    logic                can_load_s;
    logic [N-1:0]        in_ready_s;
    logic                load_s;

    logic [SRC_W-1:0]    ptr_r;
    logic                out_valid_r;
    logic [WIDTH-1:0]    out_data_r;
    logic [SRC_W-1:0]    out_src_r;

    assign mode_s = arb_mode_e'(bus.prio_mode);

    rr_arbiter #(.N(N)) u_arbiter (
        .req   (bus.in_valid),
        .ptr   (ptr_r),
        .mode  (mode_s),
        .grant (grant_s),
        .idx   (idx_s)
    );

    // Accept gating: the grant only reaches in_ready when the output slot frees up.
    always_comb begin
        can_load_s = !out_valid_r || bus.out_ready;
        in_ready_s = '0;
        // rst_n gate keeps in_ready quiet while reset is held.
        if (can_load_s && rst_n) begin
            in_ready_s = grant_s;
        end else begin
            in_ready_s = '0;
        end
        load_s = |in_ready_s;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= '0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= bus.in_data[idx_s];
            out_src_r   <= idx_s;
            if (mode_s == ARB_RR) begin
                ptr_r <= (idx_s == SRC_W'(N-1)) ? '0 : idx_s + SRC_W'(1);
            end else begin
                ptr_r <= ptr_r;
            end
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_src   = out_src_r;
endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of every channel and of the output, with a minimum of 1.
REQ-002 Parameter N, default 16, SHALL set the input channel count, with a legal range of 2..32; other values SHALL fail elaboration.
REQ-003 Localparam SRC_W SHALL equal max(1, $clog2(N)) and SHALL set the source-index width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 prio_mode  input  1  SHALL select arbitration: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-007 in_valid  input  N  SHALL carry the per-channel request/valid bits.
REQ-008 in_data  input  N x WIDTH  SHALL carry the per-channel data words (unpacked array [N]).
REQ-009 in_ready  output  N  SHALL be the per-channel accept signals (one-hot or zero).
REQ-010 out_valid  output  1  SHALL indicate that the registered output word is valid.
REQ-011 out_data  output  WIDTH  SHALL carry the registered selected word.
REQ-012 out_src  output  SRC_W  SHALL carry the channel index that produced out_data.
REQ-013 out_ready  input  1  SHALL indicate that the downstream sink accepts the output this cycle.

Function
REQ-014 A transfer on channel i SHALL occur in any cycle where in_valid[i] and in_ready[i] are both high; an output transfer SHALL occur where out_valid and out_ready are both high.
REQ-015 can_load SHALL be defined as (!out_valid || out_ready); in_ready SHALL be all-zero whenever can_load is 0.
REQ-016 When can_load is 1 and at least one in_valid bit is set, exactly one in_ready bit SHALL be high: the granted channel g.
REQ-017 Round-robin mode SHALL grant the first requesting index found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-018 Fixed mode SHALL grant the lowest requesting index and SHALL ignore ptr.
REQ-019 On a round-robin grant, ptr SHALL update to (g+1) mod N, wrapping N-1 to 0; a fixed-mode grant SHALL leave ptr unchanged.
REQ-020 Latency: a word accepted at edge T SHALL be presented on out_data/out_src with out_valid=1 after edge T, i.e. one cycle later.
REQ-021 out_data/out_src SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 A simultaneous output drain and input accept SHALL reload the register in the same cycle, sustaining one word per cycle with no bubble.
REQ-023 out_valid SHALL clear after an output transfer that has no simultaneous input grant.
REQ-024 in_ready SHALL depend combinationally only on in_valid, ptr, prio_mode, out_valid and out_ready, never on in_data.
REQ-025 A prio_mode change SHALL take effect on the next grant decision and SHALL NOT disturb a held output word.

Reset
REQ-026 While rst_n=0: out_valid=0, out_data=0, out_src=0, ptr=0, and in_ready SHALL read all-zero.
REQ-027 Reset asserted mid-operation SHALL discard any held output word without a handshake.
REQ-028 The first grant after reset release SHALL behave as if ptr=0.

Structure
REQ-029 Package arb_pkg SHALL hold the prio_mode enum (ARB_RR=0, ARB_FIXED=1) and the N range limits.
REQ-030 Grant computation SHALL be a sub-module rr_arbiter #(N) with inputs req, ptr, mode and outputs a one-hot grant and an encoded index; the output register and ptr SHALL live in rr_arb_mux.

Verification
REQ-031 N=4, RR mode, in_valid=4'b1111 held, out_ready=1: out_src SHALL be 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-032 N=4, ARB_FIXED, in_valid=4'b1010: out_src SHALL be 1 every cycle; after in_valid[1] drops, out_src SHALL be 3.
REQ-033 out_ready=0 for 3 cycles with a word held (in_data[2]=32'hDEAD_BEEF): out_data SHALL stay DEADBEEF, in_ready SHALL be 0, and ptr SHALL not move.
REQ-034 ptr=3 with only in_valid[0] set: channel 0 SHALL be granted (wrap) and ptr SHALL become 1.
REQ-035 rst_n pulsed low with out_valid=1: out_valid SHALL go 0 immediately (asynchronously), and the first post-reset grant with in_valid=4'b1111 SHALL be channel 0.
REQ-036 N=2 and N=32 elaborations SHALL pass REQ-031 equivalents; N=1 SHALL fail elaboration.
